// File: rtl/mac_accumulator.sv
// Block-floating-point product accumulator: aligns each signed product term to the
// running maximum exponent, sums with saturation and hands one result per group downstream.
module mac_accumulator #(
   parameter int MAX_TERMS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_last,
   input  logic [15:0] in_mant,
   input  logic [5:0]  in_exp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [19:0] signed_sum,
   output logic [5:0]  exp_max,
   output logic        sat
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [4:0]         LAST_COUNT = 5'(MAX_TERMS);
   localparam logic signed [20:0] POS_LIM    = 21'sd524287;
   localparam logic signed [20:0] NEG_LIM    = -21'sd524287;

   logic [1:0]  state_reg, state_next;
   logic [4:0]  count_reg, count_next;
   logic [19:0] sum_reg, sum_next;
   logic [5:0]  exp_reg, exp_next;
   logic        sat_reg, sat_next;

   logic               accept;
   logic               closing;
   logic [4:0]         count_plus;
   logic [19:0]        mant_ext;
   logic signed [6:0]  exp_diff;
   logic               shift_up;
   logic [6:0]         shift_dn;
   logic signed [19:0] acc_aligned;
   logic signed [19:0] term_aligned;
   logic signed [20:0] sum_wide;
   logic [19:0]        sum_clamped;
   logic               clamp_hit;

   // Arithmetic right shift; anything 20 or wider collapses to pure sign fill.
   function automatic logic signed [19:0] asr20(input logic signed [19:0] v,
                                                input logic [6:0] sh);
      if (sh >= 7'd20) begin
         asr20 = {20{v[19]}};
      end else begin
         asr20 = v >>> sh[4:0];
      end
   endfunction

   assign in_ready   = (state_reg != HOLD);
   assign out_valid  = (state_reg == HOLD);
   assign signed_sum = sum_reg;
   assign exp_max    = exp_reg;
   assign sat        = sat_reg;

   assign accept     = in_valid && in_ready;
   assign count_plus = (state_reg == IDLE) ? 5'd1 : count_reg + 5'd1;
   assign closing    = in_last || (count_plus == LAST_COUNT);
   assign mant_ext   = {{4{in_mant[15]}}, in_mant};

   // Align whichever operand has the smaller exponent down to the larger one.
   assign exp_diff     = $signed({in_exp[5], in_exp}) - $signed({exp_reg[5], exp_reg});
   assign shift_up     = !exp_diff[6] && (exp_diff != 7'sd0);
   assign shift_dn     = 7'(-exp_diff);
   assign acc_aligned  = shift_up ? asr20($signed(sum_reg), exp_diff) : $signed(sum_reg);
   assign term_aligned = shift_up ? $signed(mant_ext) : asr20($signed(mant_ext), shift_dn);
   assign sum_wide     = $signed({acc_aligned[19], acc_aligned})
                       + $signed({term_aligned[19], term_aligned});

   // Symmetric clamp keeps -2^19 out so the normalizer only sees 19-bit magnitudes.
   always_comb begin
      sum_clamped = sum_wide[19:0];
      clamp_hit   = 1'b0;
      if (sum_wide > POS_LIM) begin
         sum_clamped = 20'h7FFFF;
         clamp_hit   = 1'b1;
      end else if (sum_wide < NEG_LIM) begin
         sum_clamped = 20'h80001;
         clamp_hit   = 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      sum_next   = sum_reg;
      exp_next   = exp_reg;
      sat_next   = sat_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               sum_next   = mant_ext;
               exp_next   = in_exp;
               count_next = 5'd1;
               sat_next   = 1'b0;
               state_next = closing ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               count_next = count_plus;
               // A zero term still counts toward the group but must not move the exponent.
               if (in_mant != 16'd0) begin
                  sum_next = sum_clamped;
                  sat_next = sat_reg | clamp_hit;
                  if (shift_up) begin
                     exp_next = in_exp;
                  end
               end
               state_next = closing ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= 5'd0;
         sum_reg   <= 20'd0;
         exp_reg   <= 6'd0;
         sat_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         sum_reg   <= sum_next;
         exp_reg   <= exp_next;
         sat_reg   <= sat_next;
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed groups with hand-derived results,
// handshake/reset scenarios, and random groups against an integer reference model.
`timescale 1ns/1ps
module tb_mac_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_last = 1'b0;
   logic [15:0] in_mant = 16'd0;
   logic [5:0]  in_exp = 6'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [19:0] signed_sum;
   logic [5:0]  exp_max;
   logic        sat;

   int n_checks = 0;
   int n_fail   = 0;
   int g_mant[32];
   int g_exp[32];

   always #5 clk = ~clk;

   mac_accumulator #(.MAX_TERMS(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_last    (in_last),
      .in_mant    (in_mant),
      .in_exp     (in_exp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .signed_sum (signed_sum),
      .exp_max    (exp_max),
      .sat        (sat)
   );

   // Reference: plain integer block-floating-point sum over g_mant/g_exp[0..n-1].
   function automatic void model_group(input int n, output int sum, output int e, output bit s);
      int acc;
      int d;
      int sh;
      acc = g_mant[0];
      e   = g_exp[0];
      s   = 1'b0;
      for (int i = 1; i < n; i++) begin
         if (g_mant[i] == 0) continue;
         d = g_exp[i] - e;
         if (d > 0) begin
            sh  = (d > 31) ? 31 : d;
            acc = (acc >>> sh) + g_mant[i];
            e   = g_exp[i];
         end else begin
            sh  = (-d > 31) ? 31 : -d;
            acc = acc + (g_mant[i] >>> sh);
         end
         if (acc > 524287) begin
            acc = 524287;
            s   = 1'b1;
         end else if (acc < -524287) begin
            acc = -524287;
            s   = 1'b1;
         end
      end
      sum = acc;
   endfunction

   task automatic drive_group(input int n, input bit use_last);
      for (int i = 0; i < n; i++) begin
         int waited = 0;
         @(negedge clk);
         while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_timeout term=%0d actual=%b required=1", i, in_ready);
         end
         in_valid = 1'b1;
         in_mant  = 16'(g_mant[i]);
         in_exp   = 6'(g_exp[i]);
         in_last  = use_last && (i == n - 1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({out_valid, signed_sum, exp_max, sat} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_outputs actual=%b/%h/%h/%b required=0/00000/00/0",
                  out_valid, signed_sum, exp_max, sat);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready actual=%b required=1", in_ready);
      end
      $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
   endtask

   task automatic test_directed_groups();
      int t_n[9]    = '{1, 2, 2, 2, 2, 2, 3, 2, 2};
      int t_m[9][3] = '{'{1024, 0, 0}, '{512, 512, 0}, '{1000, -800, 0}, '{100, -5, 0},
                        '{-100, 50, 0}, '{-100, 3, 0}, '{512, 0, 256}, '{-3, -1, 0},
                        '{7, 5, 0}};
      int t_e[9][3] = '{'{3, 0, 0}, '{2, 4, 0}, '{5, 2, 0}, '{-32, 31, 0},
                        '{31, -32, 0}, '{-32, 31, 0}, '{0, 10, 1}, '{0, -1, 0},
                        '{0, 2, 0}};
      int t_sum[9]  = '{1024, 640, 900, -5, -100, 2, 512, -4, 6};
      int t_exp[9]  = '{3, 4, 5, 31, 31, 31, 1, 0, 2};
      int got_sum;
      int got_exp;
      for (int k = 0; k < 9; k++) begin
         for (int i = 0; i < t_n[k]; i++) begin
            g_mant[i] = t_m[k][i];
            g_exp[i]  = t_e[k][i];
         end
         drive_group(t_n[k], 1'b1);
         @(negedge clk);
         got_sum = $signed(signed_sum);
         got_exp = $signed(exp_max);
         n_checks++;
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL directed%0d_out_valid actual=%b required=1", k, out_valid);
         end
         n_checks++;
         if (got_sum != t_sum[k]) begin
            n_fail++;
            $display("FAIL directed%0d_sum actual=%0d required=%0d", k, got_sum, t_sum[k]);
         end
         n_checks++;
         if (got_exp != t_exp[k]) begin
            n_fail++;
            $display("FAIL directed%0d_exp actual=%0d required=%0d", k, got_exp, t_exp[k]);
         end
         n_checks++;
         if (sat !== 1'b0) begin
            n_fail++;
            $display("FAIL directed%0d_sat actual=%b required=0", k, sat);
         end
         $display("directed %0d: terms=%0d sum=%0d exp=%0d sat=%b", k, t_n[k], got_sum, got_exp, sat);
         release_result();
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 16; i++) begin
         g_mant[i] = -32768;
         g_exp[i]  = 0;
      end
      drive_group(15, 1'b0);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_early_close actual=%b required=0", out_valid);
      end
      drive_group(1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_auto_close actual=%b required=1", out_valid);
      end
      n_checks++;
      if (signed_sum !== 20'h80001) begin
         n_fail++;
         $display("FAIL sat_sum actual=%h required=80001", signed_sum);
      end
      n_checks++;
      if (sat !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_flag actual=%b required=1", sat);
      end
      $display("saturate: sum=%h sat=%b", signed_sum, sat);
      release_result();
   endtask

   task automatic test_hold();
      g_mant[0] = 1234;
      g_exp[0]  = -5;
      drive_group(1, 1'b1);
      // A competing term with in_last must be ignored while the result is held.
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_mant  = 16'd99;
      in_exp   = 6'd7;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, in_ready, signed_sum, exp_max, sat} !== {1'b1, 1'b0, 20'd1234, 6'h3B, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_cycle%0d actual=%b/%b/%0d/%h/%b required=1/0/1234/3b/0",
                     c, out_valid, in_ready, signed_sum, exp_max, sat);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      release_result();
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL hold_release actual=%b%b required=01", out_valid, in_ready);
      end
      $display("hold: sum=%0d exp=%0d released", $signed(signed_sum), $signed(exp_max));
   endtask

   task automatic test_back_to_back();
      g_mant[0] = -20;
      g_exp[0]  = 9;
      drive_group(1, 1'b1);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      in_mant   = 16'd3;
      in_exp    = 6'd2;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_release actual=%b%b required=01", out_valid, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++;
      if ({out_valid, signed_sum, exp_max} !== {1'b1, 20'd3, 6'd2}) begin
         n_fail++;
         $display("FAIL b2b_next_group actual=%b/%0d/%0d required=1/3/2",
                  out_valid, signed_sum, exp_max);
      end
      $display("back_to_back: sum=%0d exp=%0d", $signed(signed_sum), $signed(exp_max));
      release_result();
   endtask

   task automatic test_async_reset();
      g_mant[0] = 300;
      g_exp[0]  = 1;
      g_mant[1] = 400;
      g_exp[1]  = 1;
      drive_group(2, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, in_ready, signed_sum, exp_max, sat} !== {1'b0, 1'b1, 26'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset actual=%b/%b/%h/%h/%b required=0/1/00000/00/0",
                  out_valid, in_ready, signed_sum, exp_max, sat);
      end
      #1;
      rst = 1'b0;
      g_mant[0] = 7;
      g_exp[0]  = 1;
      drive_group(1, 1'b1);
      @(negedge clk);
      n_checks++;
      if ({out_valid, signed_sum, exp_max} !== {1'b1, 20'd7, 6'd1}) begin
         n_fail++;
         $display("FAIL after_reset_group actual=%b/%0d/%0d required=1/7/1",
                  out_valid, signed_sum, exp_max);
      end
      $display("async_reset: next group sum=%0d exp=%0d", $signed(signed_sum), $signed(exp_max));
      release_result();
   endtask

   task automatic test_random();
      int n;
      bit use_last;
      int exp_sum;
      int exp_e;
      bit exp_s;
      int got_sum;
      int got_exp;
      for (int g = 0; g < 40; g++) begin
         n = $urandom_range(1, 16);
         use_last = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) g_mant[i] = 0;
            else g_mant[i] = int'($signed(16'($urandom)));
            if (g % 2 == 0) g_exp[i] = $urandom_range(0, 3);
            else g_exp[i] = int'($signed(6'($urandom)));
         end
         model_group(n, exp_sum, exp_e, exp_s);
         drive_group(n, use_last);
         @(negedge clk);
         got_sum = $signed(signed_sum);
         got_exp = $signed(exp_max);
         n_checks++;
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rand%0d_out_valid actual=%b required=1", g, out_valid);
         end
         n_checks++;
         if (got_sum != exp_sum) begin
            n_fail++;
            $display("FAIL rand%0d_sum actual=%0d required=%0d", g, got_sum, exp_sum);
         end
         n_checks++;
         if (got_exp != exp_e) begin
            n_fail++;
            $display("FAIL rand%0d_exp actual=%0d required=%0d", g, got_exp, exp_e);
         end
         n_checks++;
         if (sat !== exp_s) begin
            n_fail++;
            $display("FAIL rand%0d_sat actual=%b required=%b", g, sat, exp_s);
         end
         $display("random %0d: terms=%0d last=%b sum=%0d exp=%0d sat=%b",
                  g, n, use_last, got_sum, got_exp, sat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_directed_groups();
      test_saturate();
      test_hold();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter: MAX_TERMS, 16, maximum number of product terms per group (1..31).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  product term presented.
REQ-005 SHALL have port: in_ready  output  1  block accepts a term this cycle.
REQ-006 SHALL have port: in_last  input  1  term is last of current group.
REQ-007 SHALL have port: in_mant  input  16  signed two's-complement product mantissa.
REQ-008 SHALL have port: in_exp  input  6  signed product exponent.
REQ-009 SHALL have port: out_valid  output  1  group result available.
REQ-010 SHALL have port: out_ready  input  1  downstream normalization stage consumes result.
REQ-011 SHALL have port: signed_sum  output  20  signed aligned accumulated sum, registered.
REQ-012 SHALL have port: exp_max  output  6  signed exponent of signed_sum, registered.
REQ-013 SHALL have port: sat  output  1  sticky flag: saturation occurred in current group.

Function
REQ-014 SHALL implement states IDLE (no term accepted), ACCUM (at least one term), HOLD (result valid).
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD; out_valid=1 only in HOLD.
REQ-016 SHALL accept a term when in_valid and in_ready are both 1 at a rising clk edge; otherwise state unchanged.
REQ-017 SHALL, on the first accepted term of a group (IDLE), load acc=sign-extended in_mant, exp_max=in_exp, count=1, sat=0.
REQ-018 SHALL, on a subsequent term, compute d=in_exp-exp_max in 7-bit signed arithmetic.
REQ-019 SHALL, if d>0, arithmetic-right-shift acc by d, add sign-extended in_mant, and set exp_max=in_exp.
REQ-020 SHALL, if d<=0, arithmetic-right-shift sign-extended in_mant by -d and add to acc; exp_max unchanged.
REQ-021 SHALL treat shifts of 20 or more as full sign fill (0 or -1); shifted-out bits are truncated, no rounding.
REQ-022 SHALL not update exp_max for a zero-mantissa subsequent term, but SHALL count it.
REQ-023 SHALL form each sum in 21 bits and clamp results above +524287 to 20'h7FFFF and below -524287 to 20'h80001, setting sat=1.
REQ-024 SHALL never output 20'h80000, keeping the magnitude within 19 bits for the normalizer.
REQ-025 SHALL transition ACCUM/IDLE to HOLD on the edge accepting a term with in_last=1 or with count reaching MAX_TERMS.
REQ-026 SHALL assert out_valid the cycle after the closing term is accepted (latency 1).
REQ-027 SHALL hold signed_sum, exp_max, and sat stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, in HOLD with out_ready=1, go to IDLE at that edge; out_valid=0 and in_ready=1 next cycle.
REQ-029 SHALL ignore in_last while in_ready=0.

Reset
REQ-030 SHALL, on rst=1, immediately clear state to IDLE, signed_sum=0, exp_max=0, sat=0, count=0, out_valid=0, independent of clk.
REQ-031 SHALL discard any partially accumulated group on reset; in_ready=1 after rst deasserts.

Verification
REQ-032 SHALL pass: single term mant=1024, exp=3, last -> next cycle out_valid=1, signed_sum=1024, exp_max=3, sat=0.
REQ-033 SHALL pass: (512,e=2) then (512,e=4,last) -> signed_sum=640, exp_max=4.
REQ-034 SHALL pass: (1000,e=5) then (-800,e=2,last) -> signed_sum=900, exp_max=5.
REQ-035 SHALL pass: 16 terms of -32768, e=0, no in_last -> auto-close at term 16, signed_sum=20'h80001, sat=1.
REQ-036 SHALL pass: result with out_ready=0 for 5 cycles -> outputs stable, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-037 SHALL pass: rst pulse mid-clock after 2 terms -> outputs 0 immediately; next group (7,e=1,last) gives signed_sum=7, exp_max=1.
